// File: rtl/serial_adder_ctrl.sv
// Bit-serial a+b+cin adder with IDLE/RUN/DONE sequencing, one full-adder cell and one carry flop.
// Optional two's-complement overflow output: define SERIAL_ADDER_OVERFLOW_EN.
//
// state  | meaning
// IDLE   | waiting for start; result registers hold the last answer
// RUN    | one result bit per edge, LSB first, WIDTH edges in total
// DONE   | single-cycle completion pulse, then back to IDLE
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_c;

  assign w_s      = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c      = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = (r_state == S_IDLE) && start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operands shift right so the full-adder cell always sees bit 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sum   <= '0;
      r_carry <= cin;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_c;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) r_cout <= w_c;
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic r_ovf;

  // On the MSB step r_carry is the carry into the MSB and w_c the carry out of it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          r_ovf <= 1'b0;
    else if (w_accept)                  r_ovf <= 1'b0;
    else if (r_state == S_RUN && w_last) r_ovf <= r_carry ^ w_c;
  end

  assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8); overflow checks only when
// SERIAL_ADDER_OVERFLOW_EN is defined.
module tb_serial_adder_ctrl;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic       overflow;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Pulses start for one accepting edge, then observes 12 cycles (cycle k = k edges after accept).
  task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                       output int lat, output int nbusy, output int npulse);
    lat = 0; nbusy = 0; npulse = 0;
    a = va; b = vb; cin = vc; start = 1'b1;
    step();
    start = 1'b0; a = 8'hA5; b = 8'h5A; cin = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (busy) nbusy++;
      if (done) begin
        npulse++;
        if (lat == 0) lat = k;
      end
      step();
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
    end
`ifdef SERIAL_ADDER_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow got %b want 0", overflow);
    end
`endif
    reset = 1'b0;
    step(); step(); step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start got busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic();
    int lat, nbusy, npulse;
    do_op(8'h0F, 8'h01, 1'b0, lat, nbusy, npulse);
    checks++;
    if (lat !== 9 || nbusy !== 9 || npulse !== 1) begin
      errors++;
      $display("FAIL basic_timing got lat=%0d busy=%0d pulses=%0d want 9 9 1", lat, nbusy, npulse);
    end
    checks++;
    if (sum !== 8'h10 || cout !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got sum=%h cout=%b want 10 0", sum, cout);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va[4]  = '{8'hFF, 8'h80, 8'h7F, 8'hFF};
    logic [7:0] vb[4]  = '{8'h01, 8'h80, 8'h01, 8'hFF};
    logic       vc[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] es[4]  = '{8'h00, 8'h01, 8'h80, 8'hFF};
    logic       ec[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic       eo[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    int lat, nbusy, npulse;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], vc[i], lat, nbusy, npulse);
      checks++;
      if (sum !== es[i] || cout !== ec[i] || npulse !== 1) begin
        errors++;
        $display("FAIL vector_%0d got sum=%h cout=%b pulses=%0d want %h %b 1", i, sum, cout, npulse, es[i], ec[i]);
      end
`ifdef SERIAL_ADDER_OVERFLOW_EN
      checks++;
      if (overflow !== eo[i]) begin
        errors++;
        $display("FAIL overflow_%0d got %b want %b", i, overflow, eo[i]);
      end
`else
      if (eo[i] === 1'bx) $display("unused");
`endif
    end
  endtask

  task automatic test_start_in_run();
    int npulse = 0;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    a = 8'hEE; b = 8'hEE; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (done) npulse++;
      step();
    end
    checks++;
    if (sum !== 8'h46 || npulse !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run got sum=%h pulses=%0d busy=%b want 46 1 0", sum, npulse, busy);
    end
  endtask

  task automatic test_reset_abort();
    int npulse = 0;
    int lat, nbusy, np2;
    a = 8'h77; b = 8'h11; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++;
      $display("FAIL abort_outputs got busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
    end
    step();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) npulse++;
      step();
    end
    checks++;
    if (npulse !== 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d active cycles want 0", npulse);
    end
    do_op(8'h05, 8'h03, 1'b0, lat, nbusy, np2);
    checks++;
    if (sum !== 8'h08 || cout !== 1'b0 || lat !== 9 || np2 !== 1) begin
      errors++;
      $display("FAIL after_abort got sum=%h cout=%b lat=%0d pulses=%0d want 08 0 9 1", sum, cout, lat, np2);
    end
  endtask

  task automatic test_back_to_back();
    int t[$];
    int bad_sum = 0;
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    step();
    for (int k = 1; k <= 32; k++) begin
      if (done) begin
        t.push_back(k);
        if (sum !== 8'h02) bad_sum++;
      end
      step();
    end
    start = 1'b0;
    checks++;
    if (t.size() !== 3) begin
      errors++;
      $display("FAIL b2b_count got %0d pulses want 3", t.size());
    end else begin
      checks++;
      if (t[0] !== 9 || t[1] - t[0] !== 10 || t[2] - t[1] !== 10) begin
        errors++;
        $display("FAIL b2b_spacing got %0d %0d %0d want 9 19 29", t[0], t[1], t[2]);
      end
    end
    checks++;
    if (bad_sum !== 0) begin
      errors++;
      $display("FAIL b2b_sum got %0d wrong sums want 0", bad_sum);
    end
    step(); step(); step(); step(); step(); step(); step(); step(); step(); step(); step();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    test_reset();
    test_basic();
    test_vectors();
    test_start_in_run();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port a  input  WIDTH  operand A, captured on the accepting edge.
REQ-006 The block SHALL have port b  input  WIDTH  operand B, captured on the accepting edge.
REQ-007 The block SHALL have port cin  input  1  carry-in, captured on the accepting edge.
REQ-008 The block SHALL have port busy  output  1  high in RUN and DONE.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse; high only in DONE.
REQ-010 The block SHALL have port sum  output  WIDTH  result register.
REQ-011 The block SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-012 The block SHALL have port overflow  output  1  two's-complement overflow flag; present only per REQ-027.

Function
REQ-013 The block SHALL compute a+b+cin bit-serially, LSB first, using a single 1-bit full-adder cell (sum = x^y^c, carry = majority(x,y,c)) and one carry flip-flop.
REQ-014 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-015 IDLE with start=1 at a rising edge: capture a, b and cin, clear the bit counter, clear sum, go to RUN; start=0 keeps the FSM in IDLE.
REQ-016 RUN: each edge SHALL add bit i of a and b plus the carry, shift the result bit into sum at the MSB end (sum shifts right), update the carry and increment the counter.
REQ-017 After exactly WIDTH RUN edges, the FSM SHALL go to DONE with sum[WIDTH-1:0] = (a+b+cin) mod 2^WIDTH and cout = bit WIDTH of a+b+cin.
REQ-018 DONE SHALL last one cycle and then go unconditionally to IDLE.
REQ-019 done SHALL be high in the cycle following the (WIDTH+1)th rising edge counted from, and including, the start-accepting edge.
REQ-020 start SHALL be ignored in RUN and DONE: it is not queued, and operands are not recaptured.
REQ-021 start held high through DONE SHALL be accepted on the first edge in IDLE, giving back-to-back operations with one IDLE cycle between them.
REQ-022 sum and cout SHALL hold their final values from DONE through IDLE until the next accepting edge.
REQ-023 The a, b and cin inputs SHALL be don't-care outside the accepting edge.

Reset
REQ-024 Asserting reset SHALL immediately force the FSM to IDLE and set busy, done, sum, cout, the carry flop, the counter, the operand registers and overflow (if present) to 0.
REQ-025 Reset during RUN or DONE SHALL abort the operation: no done pulse, and no partial result retained.
REQ-026 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-027 With macro SERIAL_ADDER_OVERFLOW_EN defined, the overflow port and logic SHALL exist; overflow = carry into MSB XOR carry out of MSB, is registered on entry to DONE, and holds like sum (REQ-022).
REQ-028 With SERIAL_ADDER_OVERFLOW_EN undefined, the overflow port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-029 a=0x0F, b=0x01, cin=0, start pulse -> busy for 9 cycles; done pulse in the 9th cycle after the accepting edge; sum=0x10, cout=0.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0 (macro defined).
REQ-031 a=0x80, b=0x80, cin=1 -> sum=0x01, cout=1, overflow=1; a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1.
REQ-032 Start pulse with 0x12+0x34, then start=1 with new operands 3 cycles later during RUN -> result 0x46, exactly one done pulse, new operands ignored.
REQ-033 Reset asserted 4 cycles into RUN -> all outputs 0 immediately and no done pulse; a fresh 0x05+0x03 afterwards -> 0x08.
REQ-034 start held high continuously with operands 1+1 -> done pulses every 10 cycles, each with sum=0x02.
